// File: rtl/imm_gen_pipe_if.sv
// Decode-stage immediate generator handshake bundle: instruction in, decoded entry out.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic              i_flush;
   logic              i_valid;
   logic              o_ready;
   logic [31:0]       i_instr;
   logic [TAG_W-1:0]  i_tag;
   logic              o_valid;
   logic              i_ready;
   logic [XLEN-1:0]   o_imm;
   logic [2:0]        o_fmt;
   logic              o_illegal;
   logic [TAG_W-1:0]  o_tag;

   modport master (
      output i_flush, i_valid, i_instr, i_tag, i_ready,
      input  o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
   );

   modport slave (
      input  i_flush, i_valid, i_instr, i_tag, i_ready,
      output o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate/format/illegal decode of a 32-bit instruction, sign-extended to XLEN; CSR forms via IMM_GEN_ZICSR_EN.
// Latency: 1 cycle from accept to o_valid when the output register is empty or draining.
// Backpressure: 2-entry skid (out + skid) keeps full rate; o_ready is the inverted skid valid register.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input logic           i_clk,
   input logic           i_rst,
   imm_gen_pipe_if.slave bus
);

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef IMM_GEN_ZICSR_EN
   localparam logic [2:0] FMT_CSR   = 3'd7;
`endif

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
      logic [XLEN-1:0] r;
      r      = '0;
      r[5:0] = v;
      return r;
   endfunction

   logic [31:0] ins;
   logic [6:0]  opc;
   logic [2:0]  funct3;
   logic        is_shift;
   logic [5:0]  shamt;
   logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
   entry_t      dec;

   assign ins      = bus.i_instr;
   assign opc      = ins[6:0];
   assign funct3   = ins[14:12];
   assign is_shift = (funct3[1:0] == 2'b01);
   // RV64 shifts use a 6-bit shamt; RV32 only has 5 bits, bit 25 belongs to funct7.
   assign shamt    = (XLEN == 64) ? ins[25:20] : {1'b0, ins[24:20]};
   assign imm_i32  = {{20{ins[31]}}, ins[31:20]};
   assign imm_s32  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b32  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u32  = {ins[31:12], 12'b0};
   assign imm_j32  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

   always_comb begin
      dec.tag     = bus.i_tag;
      dec.fmt     = FMT_NONE;
      dec.imm     = '1;
      dec.illegal = 1'b1;
      case (opc)
         7'b0000011, 7'b1100111: begin
            dec.fmt = FMT_I; dec.imm = sext32(imm_i32); dec.illegal = 1'b0;
         end
         7'b0010011: begin
            dec.illegal = 1'b0;
            if (is_shift) begin
               dec.fmt = FMT_SHAMT; dec.imm = zext6(shamt);
            end else begin
               dec.fmt = FMT_I; dec.imm = sext32(imm_i32);
            end
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               dec.illegal = 1'b0;
               if (is_shift) begin
                  dec.fmt = FMT_SHAMT; dec.imm = zext6({1'b0, ins[24:20]});
               end else begin
                  dec.fmt = FMT_I; dec.imm = sext32(imm_i32);
               end
            end
         end
         7'b0100011: begin
            dec.fmt = FMT_S; dec.imm = sext32(imm_s32); dec.illegal = 1'b0;
         end
         7'b1100011: begin
            dec.fmt = FMT_B; dec.imm = sext32(imm_b32); dec.illegal = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            dec.fmt = FMT_U; dec.imm = sext32(imm_u32); dec.illegal = 1'b0;
         end
         7'b1101111: begin
            dec.fmt = FMT_J; dec.imm = sext32(imm_j32); dec.illegal = 1'b0;
         end
         7'b0110011: begin
            dec.imm = '0; dec.illegal = 1'b0;
         end
         7'b0111011: begin
            if (XLEN == 64) begin
               dec.imm = '0; dec.illegal = 1'b0;
            end
         end
`ifdef IMM_GEN_ZICSR_EN
         7'b1110011: begin
            dec.illegal = 1'b0;
            if (funct3[2] && (funct3[1:0] != 2'b00)) begin
               dec.fmt = FMT_CSR; dec.imm = zext6({1'b0, ins[19:15]});
            end else begin
               dec.fmt = FMT_I; dec.imm = sext32(imm_i32);
            end
         end
`endif
         default: ;
      endcase
   end

   logic   out_vld, skid_vld;
   entry_t out_q, skid_q;
   logic   accept, xfer, drain;

   assign accept = bus.i_valid & ~skid_vld;
   assign xfer   = out_vld & bus.i_ready;
   assign drain  = ~out_vld | xfer;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         out_q    <= '0;
         skid_q   <= '0;
      end else if (bus.i_flush) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (drain) begin
         if (skid_vld) begin
            // skid full implies o_ready was low, so no new input can arrive here
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else if (accept) begin
            out_q    <= dec;
            out_vld  <= 1'b1;
         end else begin
            out_vld  <= 1'b0;
         end
      end else if (accept) begin
         skid_q   <= dec;
         skid_vld <= 1'b1;
      end
   end

   assign bus.o_ready   = ~skid_vld;
   assign bus.o_valid   = out_vld;
   assign bus.o_imm     = out_q.imm;
   assign bus.o_fmt     = out_q.fmt;
   assign bus.o_illegal = out_q.illegal;
   assign bus.o_tag     = out_q.tag;

endmodule
